// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate encoder: FSM state encoding, ImmOp
// select bits, the per-candidate shift table and the decode/pack rules.
// IMM_ENCODER_SPLIT_EN adds the two split states to the state encoding.
package imm_enc_pkg;

`ifdef IMM_ENCODER_SPLIT_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEARCH   = 3'd1,
        ST_EMIT     = 3'd2,
        ST_SPLIT_HI = 3'd3,
        ST_SPLIT_LO = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_EMIT   = 3'd2
    } state_e;
`endif

    // ImmOp select bits; IMM7 is the absence of IMM9.
    localparam logic [2:0] IMM7 = 3'b000;
    localparam logic [2:0] IMM9 = 3'b001;
    localparam logic [2:0] SHL1 = 3'b010;
    localparam logic [2:0] SHL7 = 3'b100;

    // Right-shift applied to the value for candidate k (element k, LSB first).
    localparam logic [7:0][3:0] CAND_SHIFT = {4'd8, 4'd8, 4'd7, 4'd7,
                                              4'd1, 4'd1, 4'd0, 4'd0};

    localparam logic [2:0] LAST_CAND = 3'd7;

    // Decode datapath: zero-extended field, optional <<1, then the 9 low bits
    // of that result are shifted left by 7.
    function automatic logic [15:0] imm_decode(input logic [8:0] field,
                                               input logic [2:0] immop);
        logic [15:0] v;
        if ((immop & IMM9) != 3'b000) begin
            v = {7'b0, field};
        end else begin
            v = {9'b0, field[6:0]};
        end
        if ((immop & SHL1) != 3'b000) begin
            v = {v[14:0], 1'b0};
        end
        if ((immop & SHL7) != 3'b000) begin
            v = {v[8:0], 7'b0};
        end
        return v;
    endfunction

    // Place a field into the 11-bit instruction immediate.
    function automatic logic [10:0] imm_pack(input logic [8:0] field,
                                             input logic [2:0] immop);
        logic [10:0] w;
        if ((immop & IMM9) != 3'b000) begin
            w = {field, 2'b00};
        end else begin
            w = {field[6:2], 4'b0000, field[1:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/imm_candidate_check.sv
// Combinational test of one encoding candidate: extracts the field for the
// candidate's shift and width, packs it, and checks that decoding the field
// with the candidate's ImmOp reproduces the value exactly.
module imm_candidate_check
    import imm_enc_pkg::*;
(
    input  logic [15:0] value_i,
    input  logic [2:0]  cand_i,
    output logic        hit_o,
    output logic [10:0] instr_o
);

    logic [8:0] field_w;
    logic [8:0] field;

    // Arithmetic shift keeps the sign, truncation leaves 9 or 7 field bits.
    always_comb begin
        field_w = 9'($signed(value_i) >>> CAND_SHIFT[cand_i]);
        if (cand_i[0]) begin
            field = field_w;
        end else begin
            field = {2'b00, field_w[6:0]};
        end
        hit_o   = (imm_decode(field, cand_i) == value_i);
        instr_o = imm_pack(field, cand_i);
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts a 16-bit constant and searches the eight ImmOp
// candidates (lowest first, one per cycle) for an exact single-word encoding.
// With IMM_ENCODER_SPLIT_EN defined, values with no single-word encoding are
// emitted as a high/low word pair; otherwise one word with out_err set.
module imm_encoder
    import imm_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_instr,
    output logic [2:0]  out_immop,
    output logic        out_regzero,
    output logic        out_last
`ifndef IMM_ENCODER_SPLIT_EN
    ,
    output logic        out_err
`endif
);

    state_e      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic [2:0]  cand_q, cand_d;
    logic [10:0] instr_q, instr_d;
    logic [2:0]  immop_q, immop_d;
    logic        regzero_q, regzero_d;
    logic        last_q, last_d;
`ifndef IMM_ENCODER_SPLIT_EN
    logic        err_q, err_d;
`endif

    logic        cand_hit;
    logic [10:0] cand_instr;

    imm_candidate_check u_cand (
        .value_i (val_q),
        .cand_i  (cand_q),
        .hit_o   (cand_hit),
        .instr_o (cand_instr)
    );

    // State register plus latched value, candidate index and output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            val_q     <= '0;
            cand_q    <= '0;
            instr_q   <= '0;
            immop_q   <= '0;
            regzero_q <= 1'b0;
            last_q    <= 1'b0;
`ifndef IMM_ENCODER_SPLIT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            cand_q    <= cand_d;
            instr_q   <= instr_d;
            immop_q   <= immop_d;
            regzero_q <= regzero_d;
            last_q    <= last_d;
`ifndef IMM_ENCODER_SPLIT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic; the output word only changes on a state transition,
    // so it stays stable while the consumer stalls.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        cand_d    = cand_q;
        instr_d   = instr_q;
        immop_d   = immop_q;
        regzero_d = regzero_q;
        last_d    = last_q;
`ifndef IMM_ENCODER_SPLIT_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    val_d  = in_value;
                    cand_d = '0;
                    if (in_value == 16'h0000) begin
                        state_d   = ST_EMIT;
                        instr_d   = '0;
                        immop_d   = IMM7;
                        regzero_d = 1'b1;
                        last_d    = 1'b1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (cand_hit) begin
                    state_d   = ST_EMIT;
                    instr_d   = cand_instr;
                    immop_d   = cand_q;
                    regzero_d = 1'b0;
                    last_d    = 1'b1;
                end else if (cand_q == LAST_CAND) begin
`ifdef IMM_ENCODER_SPLIT_EN
                    // High word carries V[15:8] so that after <<1, 9-bit
                    // truncation and <<7 it lands exactly on bits [15:8].
                    state_d   = ST_SPLIT_HI;
                    immop_d   = IMM9 | SHL1 | SHL7;
                    instr_d   = imm_pack({val_q[15], val_q[15:8]}, IMM9 | SHL1 | SHL7);
                    regzero_d = 1'b0;
                    last_d    = 1'b0;
`else
                    state_d   = ST_EMIT;
                    instr_d   = '0;
                    immop_d   = '0;
                    regzero_d = 1'b0;
                    last_d    = 1'b1;
                    err_d     = 1'b1;
`endif
                end else begin
                    cand_d = cand_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    instr_d   = '0;
                    immop_d   = '0;
                    regzero_d = 1'b0;
                    last_d    = 1'b0;
`ifndef IMM_ENCODER_SPLIT_EN
                    err_d     = 1'b0;
`endif
                end
            end
`ifdef IMM_ENCODER_SPLIT_EN
            ST_SPLIT_HI: begin
                if (out_ready) begin
                    state_d = ST_SPLIT_LO;
                    immop_d = IMM9;
                    instr_d = imm_pack({1'b0, val_q[7:0]}, IMM9);
                    last_d  = 1'b1;
                end
            end
            ST_SPLIT_LO: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    instr_d   = '0;
                    immop_d   = '0;
                    regzero_d = 1'b0;
                    last_d    = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = 1'b0;
        case (state_q)
            ST_EMIT:     out_valid = 1'b1;
`ifdef IMM_ENCODER_SPLIT_EN
            ST_SPLIT_HI: out_valid = 1'b1;
            ST_SPLIT_LO: out_valid = 1'b1;
`endif
            default:     out_valid = 1'b0;
        endcase
    end

    assign out_instr   = instr_q;
    assign out_immop   = immop_q;
    assign out_regzero = regzero_q;
    assign out_last    = last_q;
`ifndef IMM_ENCODER_SPLIT_EN
    assign out_err     = err_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder; follows IMM_ENCODER_SPLIT_EN like the RTL.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_instr;
    logic [2:0]  out_immop;
    logic        out_regzero;
    logic        out_last;
    logic        out_err;

    imm_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_immop   (out_immop),
        .out_regzero (out_regzero),
        .out_last    (out_last)
`ifndef IMM_ENCODER_SPLIT_EN
        ,
        .out_err     (out_err)
`endif
    );

`ifdef IMM_ENCODER_SPLIT_EN
    assign out_err = 1'b0;
`endif

    typedef struct {
        logic [10:0] instr;
        logic [2:0]  immop;
        logic        rz;
        logic        last;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   cur_lat = -1;
    bit   pend = 0;
    bit   have_snap = 0;
    bit   rand_rdy = 0;
    logic [17:0] snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [10:0] instr, input logic [2:0] immop,
                        input logic rz, input logic last, input logic err, input int lat);
        exp_t e;
        e.instr = instr;
        e.immop = immop;
        e.rz    = rz;
        e.last  = last;
        e.err   = err;
        e.lat   = lat;
        q.push_back(e);
    endtask

    // Reference encoder written from the field/decode rules.
    task automatic push_model(input logic [15:0] v);
        logic [15:0] f;
        logic [15:0] d;
        logic [8:0]  hf;
        int          sh;
        int          hit;
        hit = -1;
        if (v == 16'h0000) begin
            push(11'h000, 3'd0, 1'b1, 1'b1, 1'b0, 1);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (hit < 0) begin
                sh = (k < 2) ? 0 : (k < 4) ? 1 : (k < 6) ? 7 : 8;
                f  = 16'($signed(v) >>> sh);
                f  = (k % 2 == 1) ? (f & 16'h01FF) : (f & 16'h007F);
                d  = f;
                if ((k & 2) != 0) d = d << 1;
                if ((k & 4) != 0) d = (d & 16'h01FF) << 7;
                if (d == v) begin
                    hit = k;
                    if (k % 2 == 1) push(11'(f << 2), 3'(k), 1'b0, 1'b1, 1'b0, 2 + k);
                    else            push(11'(((f >> 2) << 6) | (f & 16'h3)), 3'(k), 1'b0, 1'b1, 1'b0, 2 + k);
                end
            end
        end
        if (hit < 0) begin
`ifdef IMM_ENCODER_SPLIT_EN
            hf = {v[15], v[15:8]};
            push({hf, 2'b00}, 3'd7, 1'b0, 1'b0, 1'b0, 9);
            push({1'b0, v[7:0], 2'b00}, 3'd1, 1'b0, 1'b1, 1'b0, -1);
`else
            hf = 9'h000;
            push({hf, 2'b00}, 3'd0, 1'b0, 1'b1, 1'b1, 9);
`endif
        end
    endtask

    // Output monitor: stability under stall, latency, scoreboard pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend      = 0;
            have_snap = 0;
            cur_lat   = -1;
        end else begin
            if (out_valid) begin
                if (have_snap)
                    chk("stable", 32'({out_instr, out_immop, out_regzero, out_last, out_err}), 32'(snap));
                if (pend) begin
                    cur_lat = cyc - acc_cyc;
                    pend    = 0;
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 32'(out_instr), 32'h7FF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("instr",   32'(out_instr),   32'(e.instr));
                        chk("immop",   32'(out_immop),   32'(e.immop));
                        chk("regzero", 32'(out_regzero), 32'(e.rz));
                        chk("last",    32'(out_last),    32'(e.last));
`ifndef IMM_ENCODER_SPLIT_EN
                        chk("err",     32'(out_err),     32'(e.err));
`endif
                        if (e.lat >= 0) chk("latency", 32'(cur_lat), 32'(e.lat));
                    end
                    cur_lat   = -1;
                    have_snap = 0;
                end else begin
                    snap      = {out_instr, out_immop, out_regzero, out_last, out_err};
                    have_snap = 1;
                end
            end else begin
                have_snap = 0;
            end
            if (in_valid && in_ready) begin
                pend    = 1;
                acc_cyc = cyc;
            end
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int seen;
        logic [15:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 16'h0000;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_instr",     32'(out_instr),   32'd0);
        chk("rst_immop",     32'(out_immop),   32'd0);
        chk("rst_regzero",   32'(out_regzero), 32'd0);
        chk("rst_last",      32'(out_last),    32'd0);
        chk("rst_err",       32'(out_err),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed words.
        push(11'h000, 3'd0, 1'b1, 1'b1, 1'b0, 1); send(16'h0000); drain();
        push(11'h041, 3'd0, 1'b0, 1'b1, 1'b0, 2); send(16'h0005); drain();
        push(11'h320, 3'd1, 1'b0, 1'b1, 1'b0, 3); send(16'h00C8); drain();
        push(11'h600, 3'd3, 1'b0, 1'b1, 1'b0, 5); send(16'h0300); drain();
`ifdef IMM_ENCODER_SPLIT_EN
        push(11'h048, 3'd7, 1'b0, 1'b0, 1'b0, 9);
        push(11'h0D0, 3'd1, 1'b0, 1'b1, 1'b0, -1);
`else
        push(11'h000, 3'd0, 1'b0, 1'b1, 1'b1, 9);
`endif
        send(16'h1234); drain();

        // Stall the first output word of 0x1234 for five cycles.
        out_ready = 1'b0;
`ifdef IMM_ENCODER_SPLIT_EN
        push(11'h048, 3'd7, 1'b0, 1'b0, 1'b0, 9);
        push(11'h0D0, 3'd1, 1'b0, 1'b1, 1'b0, -1);
`else
        push(11'h000, 3'd0, 1'b0, 1'b1, 1'b1, 9);
`endif
        send(16'h1234);
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("hold_wait", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
`ifdef IMM_ENCODER_SPLIT_EN
            chk("hold_instr", 32'(out_instr), 32'h048);
            chk("hold_immop", 32'(out_immop), 32'd7);
            chk("hold_last",  32'(out_last),  32'd0);
`else
            chk("hold_instr", 32'(out_instr), 32'h000);
            chk("hold_err",   32'(out_err),   32'd1);
            chk("hold_last",  32'(out_last),  32'd1);
`endif
        end
        out_ready = 1'b1;
        drain();

        // Reset while candidate 3 of 0x1234 is under test.
        send(16'h1234);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_word", 32'(seen), 32'd0);
        push(11'h041, 3'd0, 1'b0, 1'b1, 1'b0, 2); send(16'h0005); drain();

        // Boundary values through the reference model.
        push_model(16'hFFFF); send(16'hFFFF); drain();
        push_model(16'h8000); send(16'h8000); drain();
        push_model(16'hFF80); send(16'hFF80); drain();
        push_model(16'h007F); send(16'h007F); drain();
        push_model(16'h01FF); send(16'h01FF); drain();

        // Random shaped values with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            case (i % 5)
                0: v = 16'($urandom_range(0, 255));
                1: v = 16'($urandom_range(0, 511)) << 1;
                2: v = 16'($urandom_range(0, 127)) << 7;
                3: v = 16'($urandom_range(0, 511)) << 7;
                default: v = 16'($urandom);
            endcase
            push_model(v);
            send(v);
        end
        drain();
        rand_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 16-bit datapath.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_value is presented for encoding.
REQ-005 in_ready  output  1  the block accepts a value; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 in_value  input  16  constant to be encoded.
REQ-007 out_valid  output  1  one encoding word is presented.
REQ-008 out_ready  input  1  consumer accepts the word; transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-009 out_instr  output  11  instruction immediate field, bits [10:0].
REQ-010 out_immop  output  3  ImmOp select: bit0 = imm9 (else imm7), bit1 = shift left 1, bit2 = shift left 7 applied after bit1 and truncated to bits [8:0] before shifting.
REQ-011 out_regzero  output  1  the word encodes the value zero.
REQ-012 out_last  output  1  this word is the final word for the current value.
REQ-013 out_err  output  1  the value is not encodable; this output exists only when the split feature is compiled out.

Function
REQ-014 Field packing SHALL be as follows: imm7 value f[6:0] goes to instr[10:6]=f[6:2] and instr[1:0]=f[1:0], with instr[5:2]=0; imm9 value f[8:0] goes to instr[10:2]=f[8:0], with instr[1:0]=0.
REQ-015 The FSM states SHALL be IDLE, SEARCH, EMIT, SPLIT_HI and SPLIT_LO; in_ready SHALL be high only in IDLE.
REQ-016 In IDLE, on acceptance: in_value is latched; if it is 0x0000, go to EMIT with regzero=1, immop=000, instr=0; otherwise go to SEARCH with cand=0.
REQ-017 In SEARCH, one candidate SHALL be tested per cycle, in the order immop 000,001,010,011,100,101,110,111.
REQ-018 For candidate k, the field SHALL be the latched value arithmetically shifted right by 0,0,1,1,7,7,8,8 respectively and truncated to 7 or 9 bits; the candidate matches only if decoding (field, k) reproduces the latched value exactly.
REQ-019 On the first match, the FSM SHALL go to EMIT with that field and immop; lower immop values SHALL win.
REQ-020 If candidate 7 fails, the FSM SHALL go to SPLIT_HI (split feature compiled in) or to EMIT with err=1 and instr/immop=0 (split feature compiled out).
REQ-021 Latency: with acceptance at edge N, out_valid SHALL rise after edge N+1 for value zero, and after edge N+2+k for a match at candidate k; the worst case is edge N+9 (first split word).
REQ-022 EMIT SHALL drive out_valid=1 and out_last=1, and return to IDLE on transfer.
REQ-023 SPLIT_HI SHALL drive immop=111, imm9 field {V[15],V[15:8]}, last=0, and go to SPLIT_LO on transfer.
REQ-024 SPLIT_LO SHALL drive immop=001, field {1'b0,V[7:0]}, last=1, and go to IDLE on transfer.
REQ-025 While out_valid=1 and out_ready=0, every out_* signal SHALL remain stable.
REQ-026 out_valid SHALL be 0 in IDLE and SEARCH.
REQ-027 A transfer in EMIT or SPLIT_LO SHALL NOT accept a new input in the same cycle; the next acceptance is no earlier than the following edge.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_instr=0, out_immop=0, out_regzero=0, out_last=0, out_err=0, and clear the latched value and cand.
REQ-029 A reset asserted mid-SEARCH or mid-split SHALL abandon the value without emitting any word.

Configuration
REQ-030 The macro IMM_ENCODER_SPLIT_EN SHALL control the split feature.
REQ-031 With IMM_ENCODER_SPLIT_EN defined, unencodable values SHALL produce the two-word SPLIT_HI/SPLIT_LO sequence, whose decoded sum equals the value, and out_err SHALL be absent.
REQ-032 With IMM_ENCODER_SPLIT_EN undefined, the SPLIT states SHALL NOT exist and unencodable values SHALL produce one EMIT word with out_err=1 and out_last=1.

Structure
REQ-033 The shared package imm_enc_pkg SHALL hold the state enum, the ImmOp constants (IMM7, IMM9, SHL1, SHL7) and the per-candidate shift table {0,0,1,1,7,7,8,8}.
REQ-034 The sub-module imm_candidate_check SHALL perform the combinational field extraction, packing and decode-compare for one candidate, and SHALL reuse the same decode rules as the decode datapath.

Verification
REQ-035 in_value=0x0000 -> one word with regzero=1, immop=000, instr=0x000, last=1, out_valid after N+1.
REQ-036 in_value=0x0005 -> immop=000, instr=0x041, out_valid after N+2; 0x00C8 -> immop=001, instr=0x320, out_valid after N+3.
REQ-037 in_value=0x0300 -> immop=011, instr=0x600, out_valid after N+5.
REQ-038 in_value=0x1234 with IMM_ENCODER_SPLIT_EN -> word 1: immop=111, instr=0x048, last=0; word 2: immop=001, instr=0x0D0, last=1. Without the macro -> one word with err=1, last=1.
REQ-039 Hold out_ready=0 for 5 cycles during SPLIT_HI -> outputs stable and in_ready=0 throughout; a later out_ready=1 completes both words in order.
REQ-040 Pulse rst_n low at candidate 3 of 0x1234 -> no word emitted, in_ready=1 immediately; the next value 0x0005 encodes normally.
